serial_nibble_subtractor: RTL and testbench

Multi-cycle unsigned subtractor that computes `diff = a - b - bin` one nibble per clock. It uses a single 4-bit carry-lookahead subtract slice and a registered borrow chain. It is the inverse-direction companion to the team's 4-bit CLA adder. It provides a handshake-driven arithmetic unit for datapaths wider than one slice, where area matters more than latency.

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/serial_nibble_subtractor_if.sv | 21 ++
 rtl/serial_nibble_subtractor_slice.sv | 28 ++
 rtl/serial_nibble_subtractor.sv | 114 +++++++++++
 tb/tb_serial_nibble_subtractor.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the serial nibble subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int NIBBLE_W = 4;

  // Nibble counter width; a single-nibble datapath still gets a 1-bit counter.
  function automatic int idx_width(input int width);
    int nib;
    nib = width / NIBBLE_W;
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/serial_nibble_subtractor_if.sv
// Request/result bundle of the serial nibble subtractor; ovf exists only with SERIAL_SUB_OVF_EN.
interface serial_nibble_subtractor_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, zero, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, zero, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout, zero);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, zero);
`endif
endinterface

// File: rtl/serial_nibble_subtractor_slice.sv
// Combinational 4-bit carry-lookahead subtract slice: d = x - y - bi, bo = borrow-out.
module cla4_sub_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
);
  logic [3:0] yn;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Subtraction as x + ~y + ~bi, so the incoming carry is the inverted borrow.
  assign yn = ~y;
  assign g  = x & yn;
  assign p  = x ^ yn;

  assign c[0] = ~bi;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign d  = p ^ c[3:0];
  assign bo = ~c[4];
endmodule

// File: rtl/serial_nibble_subtractor.sv
// Serial a - b - bin, one nibble per clock through a single CLA slice.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_nibble_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_nibble_subtractor_if.slave bus
);
  localparam int                  NIB      = WIDTH / NIBBLE_W;
  localparam int                  CNT_W    = idx_width(WIDTH);
  localparam logic [CNT_W-1:0]    LAST_IDX = CNT_W'(NIB - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               borrow_q, borrow_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               zero_q, zero_d;
`ifdef SERIAL_SUB_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [NIBBLE_W-1:0] slice_x, slice_y, slice_d;
  logic                slice_bo;

  assign slice_x = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign slice_y = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  cla4_sub_slice u_slice (
    .x  (slice_x),
    .y  (slice_y),
    .bi (borrow_q),
    .d  (slice_d),
    .bo (slice_bo)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    if (state_q == RUN) begin
      diff_d[idx_q*NIBBLE_W +: NIBBLE_W] = slice_d;
      borrow_d = slice_bo;
      idx_d    = idx_q + 1'b1;
      if (idx_q == LAST_IDX) begin
        state_d = DONE;
        bout_d  = slice_bo;
        zero_d  = (diff_d == '0);
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
      end
    end else if (bus.start) begin
      // Accepted from IDLE or DONE; results stay held until RUN rewrites them.
      state_d  = RUN;
      idx_d    = '0;
      a_d      = bus.a;
      b_d      = bus.b;
      borrow_d = bus.bin;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.zero = zero_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_nibble_subtractor.sv
// Scoreboard bench for serial_nibble_subtractor at WIDTH=16.
module tb_serial_nibble_subtractor;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   last_done_cyc = 0;
  exp_t sb[$];

  serial_nibble_subtractor_if #(.WIDTH(W)) sif ();

  serial_nibble_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t e;
    logic [W:0] full;
    full   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    e.diff = full[W-1:0];
    e.bout = full[W];
    e.zero = (full[W-1:0] == '0);
    e.ovf  = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  // Result monitor: every done pops the oldest expected result.
  always @(negedge clk) begin
    if (!rst && sif.done) begin
      exp_t e;
      done_cnt++;
      last_done_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done with diff=%h, expected no done", sif.diff);
      end else begin
        e = sb.pop_front();
        if (sif.diff !== e.diff || sif.bout !== e.bout || sif.zero !== e.zero) begin
          errors++;
          $display("FAIL result: got diff=%h bout=%b zero=%b, expected diff=%h bout=%b zero=%b",
                   sif.diff, sif.bout, sif.zero, e.diff, e.bout, e.zero);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (sif.ovf !== e.ovf) begin
          errors++;
          $display("FAIL ovf: got %b, expected %b", sif.ovf, e.ovf);
        end
`endif
      end
    end
  end

  // Drives one request; returns the cycle stamp right after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input bit expect_result, input bit hold, output int e0);
    @(posedge clk); #1;
    sif.start = 1'b1;
    sif.a     = a;
    sif.b     = b;
    sif.bin   = bin;
    if (expect_result) sb.push_back(model(a, b, bin));
    @(posedge clk); #1;
    e0 = cyc;
    if (!hold) sif.start = 1'b0;
  endtask

  task automatic wait_done(input int e0, input int d0, output int lat);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL done_timeout: no done after %0d cycles, expected one", n);
      lat = -1;
    end else begin
      lat = last_done_cyc - e0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sif.start = 1'b0; sif.a = '0; sif.b = '0; sif.bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sif.busy !== 1'b0 || sif.done !== 1'b0 || sif.diff !== '0 || sif.bout !== 1'b0 || sif.zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b diff=%h bout=%b zero=%b, expected all 0",
               sif.busy, sif.done, sif.diff, sif.bout, sif.zero);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (sif.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b, expected 0", sif.ovf);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int e0, lat, d0;
    d0 = done_cnt;
    start_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, e0);
    checks++;
    if (sif.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b, expected 1", sif.busy);
    end
    wait_done(e0, d0, lat);
    // done appears after edge E(NIB): E0..E4 spans 5 edges.
    checks++;
    if (lat != NIB) begin
      errors++;
      $display("FAIL latency: got %0d edges after E0, expected %0d", lat, NIB);
    end
    @(negedge clk);
    checks++;
    if (sif.done !== 1'b0 || sif.diff !== 16'hFFFE || sif.bout !== 1'b1 || sif.zero !== 1'b0) begin
      errors++;
      $display("FAIL hold_after_done: got done=%b diff=%h bout=%b zero=%b, expected 0 fffe 1 0",
               sif.done, sif.diff, sif.bout, sif.zero);
    end
  endtask

  task automatic test_patterns();
    logic [W-1:0] ta[6];
    logic [W-1:0] tb[6];
    logic         tbin[6];
    ta = '{16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 16'h8000, 16'h0F0F};
    tb = '{16'h0234, 16'hABCD, 16'h0000, 16'hFFFF, 16'h0000, 16'hF0F0};
    tbin = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      int e0, lat, d0;
      logic [W-1:0] a, b;
      logic bin;
      if (i < 6) begin
        a = ta[i]; b = tb[i]; bin = tbin[i];
      end else begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
      d0 = done_cnt;
      start_op(a, b, bin, 1'b1, 1'b0, e0);
      wait_done(e0, d0, lat);
    end
  endtask

  task automatic test_start_while_busy();
    int e0, lat, d0;
    d0 = done_cnt;
    start_op(16'h4321, 16'h1234, 1'b0, 1'b1, 1'b0, e0);
    @(posedge clk); #1;
    sif.start = 1'b1; sif.a = 16'h0001; sif.b = 16'h0009; sif.bin = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    sif.start = 1'b0;
    wait_done(e0, d0, lat);
    checks++;
    if (lat != NIB) begin
      errors++;
      $display("FAIL busy_latency: got %0d, expected %0d", lat, NIB);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (done_cnt != d0 + 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL start_ignored: got %0d dones, %0d pending, expected 1 done 0 pending",
               done_cnt - d0, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int e0, e1, lat, d0, first_done;
    d0 = done_cnt;
    start_op(16'h0100, 16'h0001, 1'b0, 1'b1, 1'b1, e0);
    sif.a = 16'h7777; sif.b = 16'h7778; sif.bin = 1'b0;
    sb.push_back(model(16'h7777, 16'h7778, 1'b0));
    wait_done(e0, d0, lat);
    first_done = last_done_cyc;
    @(posedge clk); #1;
    e1 = cyc;
    sif.start = 1'b0;
    wait_done(e1, d0 + 1, lat);
    checks++;
    if (last_done_cyc - first_done != NIB + 1) begin
      errors++;
      $display("FAIL back_to_back: got %0d cycles between dones, expected %0d",
               last_done_cyc - first_done, NIB + 1);
    end
  endtask

  task automatic test_reset_mid_run();
    int e0, lat, d0;
    d0 = done_cnt;
    start_op(16'h5555, 16'h1111, 1'b0, 1'b0, 1'b0, e0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (sif.busy !== 1'b0 || sif.diff !== '0 || sif.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: got busy=%b diff=%h done=%b, expected 0 0000 0",
               sif.busy, sif.diff, sif.done);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL aborted_done: got %0d dones, expected 0", done_cnt - d0);
    end
    start_op(16'h2000, 16'h0FFF, 1'b1, 1'b1, 1'b0, e0);
    wait_done(e0, d0, lat);
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    int e0, lat, d0;
    d0 = done_cnt;
    start_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, e0);
    wait_done(e0, d0, lat);
    @(negedge clk);
    checks++;
    if (sif.ovf !== 1'b1 || sif.diff !== 16'h7FFF) begin
      errors++;
      $display("FAIL ovf_set: got ovf=%b diff=%h, expected 1 7fff", sif.ovf, sif.diff);
    end
    d0 = done_cnt;
    start_op(16'h0003, 16'h0001, 1'b0, 1'b1, 1'b0, e0);
    wait_done(e0, d0, lat);
    @(negedge clk);
    checks++;
    if (sif.ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b, expected 0", sif.ovf);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending results, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
